// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants, frame FSM state type and the seven-segment
//            code table for the HC595-driven six-digit display.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int DIGITS  = 6;
  localparam int FRAME_W = 16;
  localparam int BCD_W   = 24;
  localparam int BIN_W   = 20;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Largest value that fits in six decimal digits
  localparam logic [BIN_W-1:0] BIN_MAX = 20'd999999;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DONE     = 3'd4
  } frame_state_t;

  // Active-low common-anode segment code (bit 7 = dp, kept off)
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_hc595_bin2bcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter, 20-bit binary to 6-digit BCD.
//            One load cycle followed by 20 shift/add-3 cycles; the result and
//            overflow flag are committed together on the final step.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             overflow
);

  localparam logic [4:0] c_last_step = 5'(BIN_W - 1);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_work;
  logic [4:0]       r_cnt;
  logic             r_ovf;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_next;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in next bit
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r_work[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_work[i*4 +: 4] + 4'd3;
      end
    end
    w_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  end

  // High during the last shift step, i.e. the cycle the result is committed
  assign done = busy && (r_cnt == c_last_step);

  // Load, iterate, and commit the finished value to the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      r_cnt    <= '0;
      r_bin    <= '0;
      r_work   <= '0;
      r_ovf    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        busy   <= 1'b1;
        r_cnt  <= '0;
        r_bin  <= bin;
        r_work <= '0;
        r_ovf  <= (bin > BIN_MAX);
      end
    end else begin
      r_work <= w_next;
      r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt  <= r_cnt + 5'd1;
      if (done) begin
        busy     <= 1'b0;
        bcd      <= w_next;
        overflow <= r_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_hc595.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_hc595
// Purpose  : Six-digit seven-segment scanner. Converts disp_data to BCD,
//            builds one 16-bit {select, segment} frame per digit slot and
//            bit-serialises it into two cascaded 74HC595 shift registers.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_hc595 #(
  parameter int SCAN_CYCLES = 50000,
  parameter int SCK_HALF    = 2,
  parameter int DIGITS      = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [seg_pkg::BIN_W-1:0]  disp_data,
  input  logic                       en,
  output logic                       ds,
  output logic                       sh_cp,
  output logic                       st_cp,
  output logic                       bcd_valid,
  output logic                       frame_done
);
  import seg_pkg::*;

  localparam int              SC_W     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int              PH_W     = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SCK_HALF - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

  // Converter interface
  logic             w_conv_start;
  logic             w_conv_busy;
  logic             w_conv_done;
  logic [BCD_W-1:0] w_bcd;
  logic             w_ovf;
  logic [BIN_W-1:0] r_last_bin;

  // Scan timer
  logic [SC_W-1:0]  r_scan_cnt;
  logic             w_tick;
  logic             r_pending;

  // Frame FSM
  frame_state_t     r_state;
  logic [PH_W-1:0]  r_ph;
  logic [3:0]       r_bit;
  logic [FRAME_W-1:0] r_sreg;
  logic [2:0]       r_idx;
  logic             w_frame_start;

  // Frame mux
  logic [BCD_W-1:0]   w_upper;
  logic [7:0]         w_sel;
  logic [FRAME_W-1:0] w_frame;

  // Reconvert after reset, or whenever the input differs from the last load
  assign w_conv_start = !w_conv_busy && (!bcd_valid || (disp_data != r_last_bin));

  bin2bcd_seq u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (w_conv_start),
    .bin      (disp_data),
    .busy     (w_conv_busy),
    .done     (w_conv_done),
    .bcd      (w_bcd),
    .overflow (w_ovf)
  );

  // Remember the loaded value and flag the first completed conversion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_bin <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      if (w_conv_start) r_last_bin <= disp_data;
      if (w_conv_done)  bcd_valid  <= 1'b1;
    end
  end

  assign w_tick        = (r_scan_cnt == SC_LAST);
  assign w_frame_start = (r_state == ST_IDLE) && r_pending;

  // Free-running slot timer; ticks merge into a single pending request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
      r_pending  <= w_tick || (r_pending && !w_frame_start);
    end
  end

  // Build the frame for the current digit: blanking, dash and leading zeros
  always_comb begin
    w_upper = w_bcd >> {r_idx, 2'b00};
    w_sel   = ~(8'd1 << r_idx);
    if (!en || !bcd_valid) begin
      w_frame = {8'hFF, SEG_BLANK};
    end else if (w_ovf) begin
      w_frame = {w_sel, SEG_DASH};
    end else if ((r_idx != 3'd0) && (w_upper == '0)) begin
      w_frame = {w_sel, SEG_BLANK};
    end else begin
      w_frame = {w_sel, seg_code(w_upper[3:0])};
    end
  end

  // Serialise one frame MSB first, then pulse the storage latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ph       <= '0;
      r_bit      <= '0;
      r_sreg     <= '0;
      r_idx      <= '0;
      ds         <= 1'b0;
      sh_cp      <= 1'b0;
      st_cp      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (r_pending) begin
            ds      <= w_frame[FRAME_W-1];
            r_sreg  <= {w_frame[FRAME_W-2:0], 1'b0};
            sh_cp   <= 1'b0;
            r_ph    <= '0;
            r_bit   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            r_state <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (r_ph == PH_LAST) begin
            r_ph    <= '0;
            sh_cp   <= 1'b1;
            r_state <= ST_SHIFT_HI;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (r_ph == PH_LAST) begin
            r_ph  <= '0;
            sh_cp <= 1'b0;
            if (r_bit == 4'd15) begin
              ds      <= 1'b0;
              st_cp   <= 1'b1;
              r_state <= ST_LATCH;
            end else begin
              ds      <= r_sreg[FRAME_W-1];
              r_sreg  <= {r_sreg[FRAME_W-2:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
              r_state <= ST_SHIFT_LO;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_ph == PH_LAST) begin
            r_ph       <= '0;
            st_cp      <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_hc595.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_hc595
// Purpose  : Self-checking bench for seg_scan_hc595 (SCAN_CYCLES=100,
//            SCK_HALF=2). A pin-level monitor decodes HC595 frames; expected
//            frames come from a decimal-arithmetic display model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_hc595;

  localparam int SCAN = 100;
  localparam int SCKH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] disp_data;
  logic        en;
  logic        ds;
  logic        sh_cp;
  logic        st_cp;
  logic        bcd_valid;
  logic        frame_done;

  seg_scan_hc595 #(
    .SCAN_CYCLES (SCAN),
    .SCK_HALF    (SCKH),
    .DIGITS      (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_data  (disp_data),
    .en         (en),
    .ds         (ds),
    .sh_cp      (sh_cp),
    .st_cp      (st_cp),
    .bcd_valid  (bcd_valid),
    .frame_done (frame_done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    int          stw;
    int          len;
    bit          order_ok;
    int          idx;
  } rec_t;

  rec_t        q[$];
  rec_t        mr;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          proto_err = 0;
  int          st_rises = 0;

  logic [7:0]  segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Pin monitor state
  bit          in_frame = 1'b0;
  logic [15:0] cap = '0;
  int          nb = 0, sw = 0, ln = 0, frames_seen = 0;
  logic        p_sh = 1'b0, p_st = 1'b0, p_ds = 1'b0;

  // Decode frames from the pins: first ds=1 marks frame start (sel bit 7 = 1)
  always @(negedge clk) begin
    if (reset) begin
      in_frame    = 1'b0;
      frames_seen = 0;
      nb          = 0;
    end else begin
      if (sh_cp && st_cp) proto_err++;
      if (st_cp && !p_st) st_rises++;
      if (!in_frame) begin
        if (ds && !sh_cp) begin
          in_frame = 1'b1;
          ln = 1; nb = 0; sw = 0; cap = '0;
        end
      end else begin
        ln++;
        if (sh_cp && !p_sh) begin
          if (ds !== p_ds) proto_err++;
          cap = {cap[14:0], ds};
          nb++;
        end
        if (st_cp) sw++;
        if (frame_done) begin
          mr.frame    = cap;
          mr.nbits    = nb;
          mr.stw      = sw;
          mr.len      = ln;
          mr.order_ok = (p_st === 1'b1) && (st_cp === 1'b0);
          mr.idx      = frames_seen % 6;
          q.push_back(mr);
          frames_seen++;
          in_frame = 1'b0;
        end
      end
    end
    p_sh = sh_cp; p_st = st_cp; p_ds = ds;
  end

  // Reference display model: decimal arithmetic on the displayed value
  function automatic logic [15:0] exp_frame(int val, bit e, int idx);
    logic [7:0] sel;
    logic [7:0] seg;
    int         p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    sel = 8'hFF & ~(8'h01 << idx);
    if (!e) return 16'hFFFF;
    if (val > 999999)               seg = 8'hBF;
    else if (idx > 0 && val < p)    seg = 8'hFF;
    else                            seg = segtab[(val / p) % 10];
    return {sel, seg};
  endfunction

  function automatic logic [23:0] to_bcd(int val);
    logic [23:0] b;
    int          v;
    b = '0;
    v = val;
    for (int i = 0; i < 6; i++) begin
      b = b | (24'(v % 10) << (4 * i));
      v = v / 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic get_frame(output rec_t r, output bit got);
    int t;
    t = 0;
    got = 1'b0;
    while (q.size() == 0 && t < 400) begin
      cyc(1);
      t++;
    end
    if (q.size() > 0) begin
      r = q.pop_front();
      got = 1'b1;
    end
    check("frame_timeout", 32'(got), 32'd1);
  endtask

  task automatic check_frames(input int n, input int val, input bit e);
    rec_t r;
    bit   got;
    for (int k = 0; k < n; k++) begin
      get_frame(r, got);
      if (got) begin
        check($sformatf("frame v=%0d en=%0d idx=%0d", val, e, r.idx),
              32'(r.frame), 32'(exp_frame(val, e, r.idx)));
        check("frame_bits", 32'(r.nbits), 32'd16);
        check("st_width",   32'(r.stw),   32'(SCKH));
        check("frame_len",  32'(r.len),   32'(33 * SCKH + 1));
        check("done_after_st", 32'(r.order_ok), 32'd1);
      end
    end
  endtask

  // Change inputs, let any conversion and the in-flight frame drain, then check
  task automatic apply(input int val, input bit e);
    rec_t r;
    bit   got;
    disp_data = 20'(val);
    en        = e;
    cyc(30);
    q.delete();
    get_frame(r, got);
    q.delete();
    check_frames(6, val, e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t;
    int st0;
    int val;

    reset     = 1'b1;
    disp_data = 20'd800;
    en        = 1'b1;
    cyc(3);
    check("rst_ds",         32'(ds),         32'd0);
    check("rst_sh_cp",      32'(sh_cp),      32'd0);
    check("rst_st_cp",      32'(st_cp),      32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_bcd_valid",  32'(bcd_valid),  32'd0);

    // First conversion after reset
    reset = 1'b0;
    n = 0;
    while (!bcd_valid && n < 100) begin
      cyc(1);
      n++;
    end
    check("conv_latency", 32'(n), 32'd21);
    check("bcd_800", 32'(dut.u_conv.bcd), 32'(to_bcd(800)));
    check_frames(6, 800, 1'b1);

    // Randomised values plus range boundaries
    for (int k = 0; k < 3; k++) begin
      val = int'($urandom_range(0, 999999));
      apply(val, 1'b1);
    end
    apply(0, 1'b1);
    apply(999999, 1'b1);
    apply(1048575, 1'b1);
    apply(int'($urandom_range(1000000, 1048575)), 1'b1);

    // Input change during a conversion: finish first, restart next cycle
    disp_data = 20'd10;
    n = 0;
    while (dut.u_conv.bcd !== to_bcd(10) && n < 60) begin
      cyc(1);
      n++;
      if (n == 5) disp_data = 20'd20;
    end
    check("mid_first_latency", 32'(n), 32'd21);
    check("mid_first_value", 32'(dut.u_conv.bcd), 32'(to_bcd(10)));
    n = 0;
    while (dut.u_conv.bcd !== to_bcd(20) && n < 60) begin
      cyc(1);
      n++;
    end
    check("mid_second_latency", 32'(n), 32'd21);
    apply(20, 1'b1);

    // Blanking and resume
    apply(20, 1'b0);
    apply(20, 1'b1);

    // Reset in the middle of a frame
    q.delete();
    t = 0;
    while (!(in_frame && nb == 7) && t < 400) begin
      cyc(1);
      t++;
    end
    check("reach_bit7", 32'(nb), 32'd7);
    st0 = st_rises;
    reset = 1'b1;
    #1;
    check("midrst_ds",    32'(ds),    32'd0);
    check("midrst_sh_cp", 32'(sh_cp), 32'd0);
    check("midrst_st_cp", 32'(st_cp), 32'd0);
    cyc(3);
    check("midrst_no_latch",  32'(st_rises),  32'(st0));
    check("midrst_no_frame",  32'(q.size()),  32'd0);
    check("midrst_bcd_valid", 32'(bcd_valid), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!bcd_valid && n < 100) begin
      cyc(1);
      n++;
    end
    check("reconv_latency", 32'(n), 32'd21);
    check_frames(6, 20, 1'b1);

    check("protocol_errors", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
